tm1638_spi: RTL and testbench



---
 rtl/tm1638_spi_pkg.sv | 28 ++
 rtl/tm1638_spi_tick.sv | 31 +++
 rtl/tm1638_spi.sv | 196 +++++++++++++++++++
 tb/tb_tm1638_spi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_spi_pkg.sv
// Shared types and constants for the TM1638 serial master.
// Holds the 3-bit FSM state encoding, the request opcodes and the
// helper that builds the outgoing shift word from a request.
package tm1638_spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_SHIFT_OUT = 3'd2,
    S_WAIT_READ = 3'd3,
    S_SHIFT_IN  = 3'd4,
    S_STOP      = 3'd5
  } state_t;

  localparam logic [1:0] OP_WR1 = 2'b00;
  localparam logic [1:0] OP_WR2 = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  // Outgoing bits are sent LSB first; for two-byte writes byte A goes out
  // first, so it occupies the low half of the shift word.
  function automatic logic [15:0] load_word(input logic [17:0] req);
    if (req[17:16] == OP_WR2) begin
      return {req[7:0], req[15:8]};
    end
    return {8'h00, req[7:0]};
  endfunction

endpackage

// File: rtl/tm1638_spi_tick.sv
// Half-period timer: emits a one-cycle tick every CYCLES clocks.
// The count restarts while clear is high and after every tick, so a state
// entered on a tick (or from a cleared state) always starts a fresh period.
module tm1638_spi_tick #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running period counter, held at zero by clear and wrapped on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tm1638_spi.sv
// TM1638 three-wire master: one- or two-byte writes, or command plus key-scan read.
// Latency: request accepted on the strobe edge; busy for the whole frame plus gap.
// Requests arriving while busy are dropped; o_Busy low means ready.
module tm1638_spi
  import tm1638_spi_pkg::*;
#(
  parameter int CYCLES            = 1,
  parameter int READ_DELAY_CYCLES = 1,
  parameter int READ_WIDTH        = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  output logic                  o_Busy,
  input  logic                  i_Data_Ready,
  input  logic [17:0]           i_Data,
  output logic [READ_WIDTH-1:0] o_Data,
  output logic                  o_SPI_Stb,
  output logic                  o_SPI_Clk,
  inout  wire                   io_SPI_Dio,
  output logic [2:0]            o_Diag_State,
  output logic [17:0]           o_Diag_Data,
  output logic [3:0]            o_Diag_Addr
);

  localparam int BMAX = (READ_WIDTH > 16) ? READ_WIDTH : 16;
  localparam int BW   = $clog2(BMAX);
  localparam int WW   = $clog2(READ_DELAY_CYCLES + 1);
  localparam logic [BW-1:0] RD_LAST   = BW'(READ_WIDTH - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(READ_DELAY_CYCLES - 1);

  state_t                state;
  logic                  busy;
  logic                  stb;
  logic                  sclk;
  logic                  dio_oe;
  logic                  dio_out;
  logic [14:0]           shreg;
  logic [BW-1:0]         out_last;
  logic                  is_rd;
  logic [BW-1:0]         bit_cnt;
  logic                  half;
  logic [WW-1:0]         wait_cnt;
  logic [READ_WIDTH-2:0] in_shift;
  logic [READ_WIDTH-1:0] data;
  logic [17:0]           diag_data;
  logic [15:0]           req_word;
  logic                  dio_in;
  logic                  tick;
  logic                  tick_clr;

  assign io_SPI_Dio   = dio_oe ? dio_out : 1'bz;
  assign dio_in       = io_SPI_Dio;
  assign req_word     = load_word(i_Data);
  assign o_Busy       = busy;
  assign o_Data       = data;
  assign o_SPI_Stb    = stb;
  assign o_SPI_Clk    = sclk;
  assign o_Diag_State = state;
  assign o_Diag_Data  = diag_data;
  assign o_Diag_Addr  = diag_data[11:8];

  // Idle and the read turnaround have their own timing, so the half-period
  // timer is held there and starts clean on the next state.
  assign tick_clr = (state == S_IDLE) || (state == S_WAIT_READ);

  tm1638_spi_tick #(
    .CYCLES(CYCLES)
  ) u_tick (
    .clk  (i_Clk),
    .rst_n(i_Rst),
    .clear(tick_clr),
    .tick (tick)
  );

  // Frame sequencer with registered bus outputs
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      stb       <= 1'b1;
      sclk      <= 1'b1;
      dio_oe    <= 1'b0;
      dio_out   <= 1'b0;
      shreg     <= '0;
      out_last  <= '0;
      is_rd     <= 1'b0;
      bit_cnt   <= '0;
      half      <= 1'b0;
      wait_cnt  <= '0;
      in_shift  <= '0;
      data      <= '0;
      diag_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          busy   <= 1'b0;
          stb    <= 1'b1;
          sclk   <= 1'b1;
          dio_oe <= 1'b0;
          if (i_Data_Ready) begin
            state     <= S_START;
            busy      <= 1'b1;
            stb       <= 1'b0;
            dio_oe    <= 1'b1;
            dio_out   <= req_word[0];
            shreg     <= req_word[15:1];
            out_last  <= (i_Data[17:16] == OP_WR2) ? BW'(15) : BW'(7);
            is_rd     <= (i_Data[17:16] == OP_RD);
            diag_data <= i_Data;
          end
        end

        S_START: begin
          if (tick) begin
            state   <= S_SHIFT_OUT;
            sclk    <= 1'b0;
            half    <= 1'b0;
            bit_cnt <= '0;
          end
        end

        S_SHIFT_OUT: begin
          if (tick) begin
            if (!half) begin
              sclk <= 1'b1;
              half <= 1'b1;
            end else if (bit_cnt == out_last) begin
              dio_oe <= 1'b0;
              half   <= 1'b0;
              if (is_rd) begin
                state    <= S_WAIT_READ;
                wait_cnt <= '0;
              end else begin
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              dio_out <= shreg[0];
              shreg   <= {1'b0, shreg[14:1]};
              sclk    <= 1'b0;
              half    <= 1'b0;
            end
          end
        end

        S_WAIT_READ: begin
          if (wait_cnt == WAIT_LAST) begin
            state   <= S_SHIFT_IN;
            sclk    <= 1'b0;
            half    <= 1'b0;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_SHIFT_IN: begin
          if (tick) begin
            if (!half) begin
              sclk <= 1'b1;
              half <= 1'b1;
            end else if (bit_cnt == RD_LAST) begin
              // Only a complete read reaches here, so o_Data changes atomically.
              data  <= {dio_in, in_shift};
              state <= S_STOP;
              half  <= 1'b0;
            end else begin
              in_shift <= {dio_in, in_shift[READ_WIDTH-2:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              sclk     <= 1'b0;
              half     <= 1'b0;
            end
          end
        end

        S_STOP: begin
          if (tick) begin
            if (!half) begin
              stb  <= 1'b1;
              half <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              half  <= 1'b0;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_spi.sv
// Directed bench for tm1638_spi with a bus monitor and a key-scan slave.
// Checks reset values, write bit streams, read data, busy length and aborts.
// Expected values are hand-computed constants.
module tb_tm1638_spi;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        data_ready;
  logic [17:0] data;
  logic [31:0] odata;
  logic        stb;
  logic        sclk;
  wire         dio;
  logic [2:0]  diag_state;
  logic [17:0] diag_data;
  logic [3:0]  diag_addr;

  int n_chk  = 0;
  int n_pass = 0;

  // slave model controls
  logic        rd_mode = 1'b0;
  logic [31:0] slave_word = 32'h0;
  logic        slave_en;
  logic        slave_val;

  // monitor state
  int          fall_cnt = 0;
  int          rise_cnt = 0;
  logic [47:0] wbits = '0;
  int          gap_run = 0;
  int          last_gap = 0;
  int          busy_run = 0;
  logic        dio_at_wait = 1'b0;
  logic        prev_stb = 1'b1;
  logic        prev_sclk = 1'b1;
  logic        prev_busy = 1'b0;

  tm1638_spi dut (
    .i_Clk        (clk),
    .i_Rst        (rst_n),
    .o_Busy       (busy),
    .i_Data_Ready (data_ready),
    .i_Data       (data),
    .o_Data       (odata),
    .o_SPI_Stb    (stb),
    .o_SPI_Clk    (sclk),
    .io_SPI_Dio   (dio),
    .o_Diag_State (diag_state),
    .o_Diag_Data  (diag_data),
    .o_Diag_Addr  (diag_addr)
  );

  pullup pu_dio (dio);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave drives read bit k after the (9+k)-th falling SPI clock of a read frame
  always_comb begin
    slave_en  = rd_mode && !stb && (fall_cnt >= 9) && (fall_cnt <= 40);
    slave_val = 1'b1;
    if (slave_en) slave_val = slave_word[fall_cnt - 9];
  end
  assign dio = slave_en ? slave_val : 1'bz;

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (prev_stb && !stb) begin
      rise_cnt = 0;
      wbits    = '0;
      last_gap = gap_run;
    end
    if (stb) begin
      gap_run  = gap_run + 1;
      fall_cnt = 0;
    end else begin
      gap_run = 0;
      if (prev_sclk && !sclk) fall_cnt = fall_cnt + 1;
      if (!prev_sclk && sclk) begin
        if (rise_cnt < 48) wbits[rise_cnt] = dio;
        rise_cnt = rise_cnt + 1;
      end
    end
    if (busy && !prev_busy) busy_run = 1;
    else if (busy) busy_run = busy_run + 1;
    if (diag_state == 3'd3) dio_at_wait = dio;
    prev_stb  = stb;
    prev_sclk = sclk;
    prev_busy = busy;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Present a request for one cycle; called #1 after a rising edge
  task automatic send(input logic [17:0] req);
    data       = req;
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_idle_timeout"}, busy, 1'b0);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_stb"},  stb,  1'b1);
    check({tag, "_sclk"}, sclk, 1'b1);
    check({tag, "_dio"},  dio,  1'b1);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    data_ready = 1'b0;
    data       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_bus("rst");
    check("rst_odata", odata, 32'h0);
    check("rst_state", diag_state, 3'd0);
    check("rst_diag_data", diag_data, 18'h0);
    check("rst_diag_addr", diag_addr, 4'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_bus("idle");

    // Abort a read in SHIFT_IN: no prior read, so o_Data must stay at zero
    slave_word = 32'h1234_5678;
    rd_mode    = 1'b1;
    send({2'b10, 8'h02, 8'h02});
    n = 0;
    while (diag_state != 3'd4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach_shift_in", diag_state, 3'd4);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_bus("abort");
    check("abort_state", diag_state, 3'd0);
    check("abort_odata", odata, 32'h0);
    check("abort_diag_data", diag_data, 18'h0);
    rd_mode = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // op 00: single byte 0x01
    send({2'b00, 8'h00, 8'h01});
    check("wr1_busy_rise", busy, 1'b1);
    check("wr1_state_start", diag_state, 3'd1);
    wait_idle("wr1");
    check("wr1_busy_len", busy_run, 19);
    check("wr1_pulses", rise_cnt, 8);
    check("wr1_bits", wbits[7:0], 8'h01);
    check("wr1_diag_data", diag_data, 18'h00001);
    check("wr1_odata_hold", odata, 32'h0);
    check_idle_bus("wr1_after");

    // op 01: A=0x80 then B=0x02, with an ignored strobe mid-frame
    send({2'b01, 8'h80, 8'h02});
    data       = 18'h00055;
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    wait_idle("wr2");
    check("wr2_busy_len", busy_run, 35);
    check("wr2_pulses", rise_cnt, 16);
    check("wr2_bits", wbits[15:0], 16'h0280);
    check("wr2_diag_data", diag_data, 18'h18002);
    check("wr2_diag_addr", diag_addr, 4'h0);

    // op 10 issued immediately when busy drops
    slave_word = 32'hA5A5_0F0F;
    rd_mode    = 1'b1;
    send({2'b10, 8'h02, 8'h02});
    wait_idle("rd");
    rd_mode = 1'b0;
    check("rd_gap", (last_gap >= 1), 1'b1);
    check("rd_busy_len", busy_run, 84);
    check("rd_pulses", rise_cnt, 40);
    check("rd_cmd_bits", wbits[7:0], 8'h02);
    check("rd_dio_released", dio_at_wait, 1'b1);
    check("rd_odata", odata, 32'hA5A5_0F0F);
    check("rd_diag_addr", diag_addr, 4'h2);

    // op 11 behaves as a single-byte write
    @(posedge clk); #1;
    send({2'b11, 8'hFF, 8'h5A});
    wait_idle("op11");
    check("op11_busy_len", busy_run, 19);
    check("op11_pulses", rise_cnt, 8);
    check("op11_bits", wbits[7:0], 8'h5A);
    check("op11_diag_addr", diag_addr, 4'hF);
    check("op11_odata_hold", odata, 32'hA5A5_0F0F);
    check_idle_bus("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
